// File: rtl/aq_gemac_udp_pkg.sv
// Shared types and defaults for the UDP send packer slice.
package aq_gemac_udp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned FIFO_AW_DEFAULT   = 9;
  localparam int unsigned PKT_WORDS_DEFAULT = 256;
  localparam int unsigned TIMEOUT_DEFAULT   = 1000;

endpackage

// File: rtl/aq_gemac_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is visible on rdata while not empty.
module aq_gemac_sync_fifo #(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_ok;
  logic        rd_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count = wr_ptr - rd_ptr;
    wr_ok = we & ~full;
    rd_ok = re & ~empty;
    rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/aq_gemac_udp_send_packer.sv
// Buffers a user word stream and cuts it into UDP datagrams (full, timeout or flush),
// driving the SEND_REQUEST / SEND_BUSY / SEND_DATA handshake of the UDP controller.
module aq_gemac_udp_send_packer
  import aq_gemac_udp_pkg::*;
#(
  parameter int unsigned FIFO_AW   = FIFO_AW_DEFAULT,
  parameter int unsigned PKT_WORDS = PKT_WORDS_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic               RST_N,
  input  logic               CLK,
  input  logic [15:0]        CFG_DSTPORT,
  input  logic [15:0]        CFG_SRCPORT,
  input  logic               WR_EN,
  input  logic [31:0]        WR_DATA,
  output logic               WR_FULL,
  input  logic               FLUSH,
  output logic [FIFO_AW:0]   FIFO_COUNT,
  output logic               OVERFLOW,
  output logic [15:0]        PKT_COUNT,
  output logic               SEND_REQUEST,
  output logic [15:0]        SEND_LENGTH,
  input  logic               SEND_BUSY,
  output logic [15:0]        SEND_DSTPORT,
  output logic [15:0]        SEND_SRCPORT,
  output logic               SEND_DATA_VALID,
  input  logic               SEND_DATA_READ,
  output logic [31:0]        SEND_DATA
);

  localparam logic [FIFO_AW:0] PKT_N = (FIFO_AW + 1)'(PKT_WORDS);
  localparam logic [31:0]      TO    = 32'(TIMEOUT);

  state_t             state;
  state_t             state_nx;
  logic [FIFO_AW:0]   count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_accept;
  logic               pop;
  logic               has_data;
  logic               trigger;
  logic               fire;
  logic [FIFO_AW:0]   n_words;
  logic [FIFO_AW:0]   remaining;
  logic [31:0]        timer;
  logic               flush_pend;

  aq_gemac_sync_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (WR_EN),
    .wdata (WR_DATA),
    .re    (pop),
    .rdata (SEND_DATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign WR_FULL    = fifo_full;
  assign FIFO_COUNT = count;

  // Every trigger term also needs buffered data, so a stale flush never yields a 0-byte datagram.
  always_comb begin
    wr_accept = WR_EN & ~fifo_full;
    has_data  = (count != '0);
    trigger   = ~SEND_BUSY & has_data &
                ((count >= PKT_N) | flush_pend | ((TO != '0) & (timer == TO)));
    fire      = (state == ST_IDLE) & trigger;
    n_words   = (count >= PKT_N) ? PKT_N : count;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (trigger)            state_nx = ST_REQ;
      ST_REQ:  if (SEND_BUSY)          state_nx = ST_XFER;
      ST_XFER: if (remaining == '0)    state_nx = ST_DONE;
      ST_DONE: if (!SEND_BUSY)         state_nx = ST_IDLE;
      default:                         state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    SEND_REQUEST    = (state == ST_REQ);
    SEND_DATA_VALID = (state == ST_XFER) & (remaining != '0) & ~fifo_empty;
    pop             = SEND_DATA_VALID & SEND_DATA_READ;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      remaining    <= '0;
      SEND_LENGTH  <= '0;
      SEND_DSTPORT <= '0;
      SEND_SRCPORT <= '0;
      timer        <= '0;
      flush_pend   <= 1'b0;
      OVERFLOW     <= 1'b0;
      PKT_COUNT    <= '0;
    end else begin
      if (fire) begin
        remaining    <= n_words;
        SEND_LENGTH  <= 16'({n_words, 2'b00});
        SEND_DSTPORT <= CFG_DSTPORT;
        SEND_SRCPORT <= CFG_SRCPORT;
      end else if (pop) begin
        remaining <= remaining - 1'b1;
      end

      if (wr_accept)
        timer <= '0;
      else if ((state == ST_IDLE) && has_data && (timer != TO))
        timer <= timer + 1'b1;

      if (fire)
        flush_pend <= 1'b0;
      else if (FLUSH && has_data)
        flush_pend <= 1'b1;

      if (WR_EN && fifo_full) OVERFLOW <= 1'b1;

      if ((state == ST_DONE) && !SEND_BUSY) PKT_COUNT <= PKT_COUNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_aq_gemac_udp_send_packer.sv
// Scoreboard bench: stimulus queues expected words/datagrams, a monitor pops and compares.
module tb_aq_gemac_udp_send_packer;

  typedef struct {
    logic [15:0] len;
    logic [15:0] dst;
    logic [15:0] src;
  } pkt_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] CFG_DSTPORT = 16'h0000;
  logic [15:0] CFG_SRCPORT = 16'h0000;
  logic        WR_EN = 1'b0;
  logic [31:0] WR_DATA = '0;
  logic        WR_FULL;
  logic        FLUSH = 1'b0;
  logic [9:0]  FIFO_COUNT;
  logic        OVERFLOW;
  logic [15:0] PKT_COUNT;
  logic        SEND_REQUEST;
  logic [15:0] SEND_LENGTH;
  logic        SEND_BUSY = 1'b0;
  logic [15:0] SEND_DSTPORT;
  logic [15:0] SEND_SRCPORT;
  logic        SEND_DATA_VALID;
  logic        SEND_DATA_READ = 1'b0;
  logic [31:0] SEND_DATA;

  aq_gemac_udp_send_packer #(.FIFO_AW(9), .PKT_WORDS(256), .TIMEOUT(1000)) dut (
    .RST_N           (RST_N),
    .CLK             (CLK),
    .CFG_DSTPORT     (CFG_DSTPORT),
    .CFG_SRCPORT     (CFG_SRCPORT),
    .WR_EN           (WR_EN),
    .WR_DATA         (WR_DATA),
    .WR_FULL         (WR_FULL),
    .FLUSH           (FLUSH),
    .FIFO_COUNT      (FIFO_COUNT),
    .OVERFLOW        (OVERFLOW),
    .PKT_COUNT       (PKT_COUNT),
    .SEND_REQUEST    (SEND_REQUEST),
    .SEND_LENGTH     (SEND_LENGTH),
    .SEND_BUSY       (SEND_BUSY),
    .SEND_DSTPORT    (SEND_DSTPORT),
    .SEND_SRCPORT    (SEND_SRCPORT),
    .SEND_DATA_VALID (SEND_DATA_VALID),
    .SEND_DATA_READ  (SEND_DATA_READ),
    .SEND_DATA       (SEND_DATA)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_data[$];
  pkt_t        exp_pkt[$];
  int          total_pops = 0;
  logic        req_q = 1'b0;
  logic        hold_busy = 1'b0;
  logic        rand_read = 1'b0;
  pkt_t        mon_p;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares every request and every popped word against the scoreboard.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (SEND_REQUEST && !req_q) begin
        if (exp_pkt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_request actual_len=%0d required=none", SEND_LENGTH);
        end else begin
          mon_p = exp_pkt.pop_front();
          chk("send_length", 64'(SEND_LENGTH), 64'(mon_p.len));
          chk("send_dstport", 64'(SEND_DSTPORT), 64'(mon_p.dst));
          chk("send_srcport", 64'(SEND_SRCPORT), 64'(mon_p.src));
        end
      end
      if (SEND_DATA_VALID && SEND_DATA_READ) begin
        total_pops <= total_pops + 1;
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", SEND_DATA);
        end else begin
          chk("send_data", 64'(SEND_DATA), 64'(exp_data.pop_front()));
        end
      end
    end
    req_q <= SEND_REQUEST & RST_N;
  end

  // UDP controller model: BUSY two cycles after REQUEST, reads n words, then releases BUSY.
  initial begin : udp_model
    int m_st, m_dly, m_n, m_base;
    m_st = 0; m_dly = 0; m_n = 0; m_base = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        m_st = 0;
        SEND_BUSY = 1'b0;
        SEND_DATA_READ = 1'b0;
      end else begin
        case (m_st)
          0: if (SEND_REQUEST && !hold_busy) begin m_dly = 0; m_st = 1; end
          1: begin
            m_dly++;
            if (m_dly == 2) begin
              SEND_BUSY = 1'b1;
              m_n = int'(SEND_LENGTH >> 2);
              m_base = total_pops;
              m_st = 2;
            end
          end
          2: begin
            if (total_pops - m_base >= m_n) begin
              SEND_DATA_READ = 1'b0;
              m_st = 3;
            end else begin
              SEND_DATA_READ = rand_read ? 1'($urandom_range(0, 1)) : 1'b1;
            end
          end
          3: begin
            chk("valid_after_n_pops", 64'(SEND_DATA_VALID), 64'(0));
            m_dly = 0;
            m_st = 4;
          end
          default: begin
            m_dly++;
            if (m_dly == 2) begin SEND_BUSY = 1'b0; m_st = 0; end
          end
        endcase
      end
    end
  end

  task automatic write_words(input int base, input int num, input int keep);
    for (int i = 0; i < num; i++) begin
      @(posedge CLK); #1;
      WR_EN = 1'b1;
      WR_DATA = 32'(base + i);
      if (i < keep) exp_data.push_back(32'(base + i));
    end
    @(posedge CLK); #1;
    WR_EN = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge CLK); #1 FLUSH = 1'b1;
    @(posedge CLK); #1 FLUSH = 1'b0;
  endtask

  task automatic push_pkt(input logic [15:0] len);
    pkt_t p;
    p.len = len;
    p.dst = CFG_DSTPORT;
    p.src = CFG_SRCPORT;
    exp_pkt.push_back(p);
  endtask

  task automatic wait_pkts(input logic [15:0] target, input int budget, input string name);
    int c;
    c = 0;
    while (PKT_COUNT != target && c < budget) begin
      @(negedge CLK);
      c++;
    end
    repeat (2) @(negedge CLK);
    chk(name, 64'(PKT_COUNT), 64'(target));
    chk({name, "_words_left"}, 64'(exp_data.size()), 64'(0));
    chk({name, "_fifo_count"}, 64'(FIFO_COUNT), 64'(0));
  endtask

  initial begin : stimulus
    int c;
    #1;
    chk("reset_outputs_a", 64'({SEND_REQUEST, SEND_DATA_VALID, WR_FULL, OVERFLOW,
                                FIFO_COUNT, PKT_COUNT, SEND_LENGTH}), 64'(0));
    chk("reset_outputs_b", {SEND_DSTPORT, SEND_SRCPORT, SEND_DATA}, 64'(0));
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    CFG_DSTPORT = 16'h1234;
    CFG_SRCPORT = 16'hABCD;

    // Full 256-word packet
    push_pkt(16'd1024);
    write_words(0, 256, 256);
    wait_pkts(16'd1, 3000, "full_packet");

    // Partial packet on idle timeout
    CFG_DSTPORT = 16'h0050;
    push_pkt(16'd40);
    write_words(1000, 10, 10);
    repeat (500) @(negedge CLK);
    chk("no_early_timeout", 64'(SEND_REQUEST), 64'(0));
    chk("timeout_fifo_count", 64'(FIFO_COUNT), 64'(10));
    c = 500;
    while (!SEND_REQUEST && c < 1500) begin @(negedge CLK); c++; end
    chk("timeout_window", 64'(c >= 995 && c <= 1010), 64'(1));
    wait_pkts(16'd2, 1000, "timeout_packet");

    // Explicit flush, then flush with nothing buffered
    push_pkt(16'd12);
    write_words(2000, 3, 3);
    repeat (2) @(posedge CLK);
    pulse_flush();
    wait_pkts(16'd3, 1000, "flush_packet");
    pulse_flush();
    repeat (50) @(negedge CLK);
    chk("empty_flush_no_request", 64'(SEND_REQUEST), 64'(0));
    chk("empty_flush_pkt_count", 64'(PKT_COUNT), 64'(3));

    // Overflow while the controller holds BUSY low
    hold_busy = 1'b1;
    push_pkt(16'd1024);
    push_pkt(16'd1024);
    write_words(3000, 600, 512);
    @(negedge CLK);
    chk("overflow_full", 64'(WR_FULL), 64'(1));
    chk("overflow_count", 64'(FIFO_COUNT), 64'(512));
    chk("overflow_flag", 64'(OVERFLOW), 64'(1));
    chk("overflow_request_held", 64'(SEND_REQUEST), 64'(1));
    hold_busy = 1'b0;
    wait_pkts(16'd5, 4000, "overflow_packets");
    chk("overflow_sticky", 64'(OVERFLOW), 64'(1));

    // Random read gaps with writes during the transfer; flush the 44-word tail
    rand_read = 1'b1;
    push_pkt(16'd1024);
    push_pkt(16'd176);
    write_words(5000, 300, 300);
    pulse_flush();
    wait_pkts(16'd7, 6000, "random_read_packets");
    rand_read = 1'b0;

    // Reset in the middle of a transfer
    push_pkt(16'd1024);
    write_words(8000, 256, 256);
    c = 0;
    while (exp_data.size() > 156 && c < 3000) begin @(negedge CLK); c++; end
    chk("reset_reached_100_words", 64'(exp_data.size()), 64'(156));
    #2 RST_N = 1'b0;
    #1;
    chk("midxfer_reset_a", 64'({SEND_REQUEST, SEND_DATA_VALID, WR_FULL, OVERFLOW,
                                FIFO_COUNT, PKT_COUNT, SEND_LENGTH}), 64'(0));
    chk("midxfer_reset_b", {SEND_DSTPORT, SEND_SRCPORT, SEND_DATA}, 64'(0));
    exp_data.delete();
    exp_pkt.delete();
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    push_pkt(16'd16);
    write_words(9000, 4, 4);
    pulse_flush();
    wait_pkts(16'd1, 1000, "post_reset_packet");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aq_gemac_udp_send_packer.md
Name: aq_gemac_udp_send_packer

Overview:
Upstream stage feeding the UDP send interface of the IP controller. It accepts a free-running 32-bit user word stream and buffers it in a first-word-fall-through (FWFT) FIFO. It cuts the stream into UDP datagrams: a full packet of PKT_WORDS words, or a shorter packet on idle timeout or explicit flush. For each datagram it runs the SEND_REQUEST / SEND_BUSY / SEND_DATA_VALID / SEND_DATA_READ handshake. Runs entirely in the SYS_CLK domain.

Parameters:
FIFO_AW, 9, FIFO address width; depth = 2^FIFO_AW = 512 words
PKT_WORDS, 256, words per full datagram (1024 bytes); must be ≤ 2^FIFO_AW and ≤ 16383
TIMEOUT, 1000, idle cycles after the last write before a partial packet is flushed; 0 disables the timeout

Ports:
RST_N  in  1  asynchronous active-low reset
CLK  in  1  system clock (SYS_CLK)
CFG_DSTPORT  in  16  UDP destination port; sampled at request
CFG_SRCPORT  in  16  UDP source port; sampled at request
WR_EN  in  1  user write strobe
WR_DATA  in  32  user data word
WR_FULL  out  1  FIFO full
FLUSH  in  1  one-cycle pulse: send buffered words now
FIFO_COUNT  out  FIFO_AW+1  current FIFO occupancy in words
OVERFLOW  out  1  sticky flag: a write was dropped; cleared only by reset
PKT_COUNT  out  16  datagrams completed; wraps 0xFFFF→0
SEND_REQUEST  out  1  to UDP controller
SEND_LENGTH  out  16  payload length in bytes = words*4
SEND_BUSY  in  1  from UDP controller
SEND_DSTPORT  out  16  latched CFG_DSTPORT
SEND_SRCPORT  out  16  latched CFG_SRCPORT
SEND_DATA_VALID  out  1  SEND_DATA holds a valid word
SEND_DATA_READ  in  1  consumer pop strobe
SEND_DATA  out  32  FWFT FIFO head

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; flush_pend=0; timer=0.
- Write: accepted when WR_EN=1 and the FIFO is not full; occupancy is visible the next cycle. WR_EN while full: word dropped, OVERFLOW set. A write and a pop in the same cycle leave the count unchanged.
- Timer: cleared on any accepted write. Counts only in IDLE with count>0. Saturates at TIMEOUT.
- FLUSH sets flush_pend if count>0; otherwise it is ignored. flush_pend clears when a request is issued.
- States:
  - IDLE: trigger = (count ≥ PKT_WORDS) | flush_pend | (TIMEOUT≠0 & timer==TIMEOUT & count>0).
    - On trigger: n = min(count, PKT_WORDS); latch n, SEND_LENGTH = n<<2, and the ports; go to REQ.
    - IDLE also waits for SEND_BUSY=0 before triggering.
  - REQ: SEND_REQUEST=1, held until SEND_BUSY=1 is sampled. Then drop SEND_REQUEST next cycle and go to XFER.
  - XFER: SEND_DATA_VALID = (remaining>0) & FIFO not empty.
    - A word is consumed on VALID & READ; remaining is decremented.
    - READ while VALID=0 is ignored (no pop, no underflow).
    - remaining==0 → DONE.
  - DONE: VALID=0. On SEND_BUSY=0: PKT_COUNT++, go to IDLE.
- n is fixed at request time. Writes that arrive during a transfer stay in the FIFO for the next packet.
- Reset asserted mid-packet: immediate return to reset values; the FIFO contents are lost.
- SEND_LENGTH, SEND_DSTPORT and SEND_SRCPORT are stable from REQ until DONE exits.

Decomposition:
- Package aq_gemac_udp_pkg: state encodings (IDLE, REQ, XFER, DONE) and defaults for PKT_WORDS and TIMEOUT.
- One sub-module: aq_gemac_sync_fifo.
  - Single-clock FWFT FIFO, parameter AW.
  - Ports: we, wdata, re, rdata, full, empty, count.
  - Empty/full use AW+1-bit pointers with an MSB wrap compare.
- The packer module holds the FSM, timer and counters.

Test Plan:
- Write 256 words 0..255 back-to-back; UDP model raises BUSY 2 cycles after REQUEST and asserts READ continuously → SEND_LENGTH=1024, 256 words in order 0..255, PKT_COUNT=1, FIFO_COUNT=0.
- Write 10 words then idle → after 1000 idle cycles, REQUEST with SEND_LENGTH=40; exactly 10 words transferred.
- Write 3 words, pulse FLUSH at cycle 5 → SEND_LENGTH=12. FLUSH with an empty FIFO → no REQUEST.
- Write 600 words continuously with SEND_BUSY stuck 0 → WR_FULL at 512, OVERFLOW=1, 88 words dropped. Release BUSY → two packets of 1024 and 1024 bytes, 512 words total in order.
- Random READ gaps (50% duty) plus concurrent writes during XFER → no duplicated or lost words; VALID drops after exactly n pops; the next packet starts with the first post-request word.
- Assert RST_N low mid-XFER after 100 words → all outputs 0 in the same cycle. After release, 4 words plus FLUSH → a clean packet with SEND_LENGTH=16.
